// File: rtl/inst_issue_queue.sv
// Instruction-issue FIFO feeding the core's raw inst input, with NOP insertion and writeback tracking.
// Optional macro INST_ISSUE_PERF_EN adds the bubble_cnt output (inserted-NOP counter).
module inst_issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_inst,
  output logic             in_ready,
  input  logic             issue_en,
  input  logic             flush,
  output logic [7:0]       inst_out,
  output logic [AW:0]      fifo_count,
  output logic             busy,
`ifdef INST_ISSUE_PERF_EN
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]       mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [7:0]       inst_out_q, inst_out_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [2:0]       wb_track_q, wb_track_d;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  assign push = in_valid && !full && !flush;
  assign pop  = issue_en && !empty && !flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    inst_out_d   = 8'h00;
    issued_cnt_d = issued_cnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        inst_out_d   = head;
        issued_cnt_d = issued_cnt_q + 1'b1;
      end
    end
    // Stage 0 mirrors ID; stages 1 and 2 cover EX and WB.
    wb_track_d = {wb_track_q[1:0], (inst_out_d[7:6] != 2'b00)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      inst_out_q   <= 8'h00;
      issued_cnt_q <= '0;
      wb_track_q   <= 3'b000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      inst_out_q   <= inst_out_d;
      issued_cnt_q <= issued_cnt_d;
      wb_track_q   <= wb_track_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= in_inst;
  end

`ifdef INST_ISSUE_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, !pop};
  end

  always_ff @(posedge clk) begin
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign in_ready   = !full;
  assign inst_out   = inst_out_q;
  assign fifo_count = count;
  assign issued_cnt = issued_cnt_q;
  // Register file is written at the end of WB, so busy drops the cycle after.
  assign busy = !empty || (inst_out_q[7:6] != 2'b00) || (wb_track_q[2:1] != 2'b00);

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed + randomized bench for inst_issue_queue, checked against a queue-based pipeline model.
module tb_inst_issue_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, in_valid, issue_en, flush;
  logic [7:0]       in_inst;
  logic             in_ready, busy;
  logic [7:0]       inst_out;
  logic [AW:0]      fifo_count;
  logic [CNT_W-1:0] issued_cnt;
`ifdef INST_ISSUE_PERF_EN
  logic [CNT_W-1:0] bubble_cnt;
`endif

  inst_issue_queue #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
    .in_ready(in_ready), .issue_en(issue_en), .flush(flush),
    .inst_out(inst_out), .fifo_count(fifo_count), .busy(busy),
`ifdef INST_ISSUE_PERF_EN
    .bubble_cnt(bubble_cnt),
`endif
    .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: host queue plus the instructions sitting in ID, EX and WB.
  logic [7:0]       q[$];
  logic [7:0]       m_id, m_ex, m_wb;
  logic [CNT_W-1:0] m_issued, m_bubble;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic       can_take;
    logic       took;
    logic [7:0] next_id;
    if (rst) begin
      q.delete();
      m_id = 8'h00; m_ex = 8'h00; m_wb = 8'h00;
      m_issued = '0; m_bubble = '0;
    end else begin
      can_take = (q.size() < DEPTH);
      took     = issue_en && (q.size() > 0) && !flush;
      next_id  = took ? q[0] : 8'h00;
      if (flush) q.delete();
      else begin
        if (took) void'(q.pop_front());
        if (in_valid && can_take) q.push_back(in_inst);
      end
      if (took) m_issued++;
      else      m_bubble++;
      m_wb = m_ex; m_ex = m_id; m_id = next_id;
    end
  endtask

  function automatic logic model_busy();
    return (q.size() != 0) || (m_id[7:6] != 0) || (m_ex[7:6] != 0) || (m_wb[7:6] != 0);
  endfunction

  task automatic check_all();
    chk("inst_out", 32'(inst_out), 32'(m_id));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("busy", 32'(busy), 32'(model_busy()));
    chk("issued_cnt", 32'(issued_cnt), 32'(m_issued));
`ifdef INST_ISSUE_PERF_EN
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
`endif
  endtask

  task automatic step(input logic v, input logic [7:0] inst, input logic ien,
                      input logic fl, input logic r);
    in_valid = v; in_inst = inst; issue_en = ien; flush = fl; rst = r;
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    $display("t=%0t rst=%0d v=%0d in=%02h ien=%0d fl=%0d -> out=%02h cnt=%0d busy=%0d iss=%0d",
             $time, r, v, inst, ien, fl, inst_out, fifo_count, busy, issued_cnt);
  endtask

  initial begin
    logic [CNT_W-1:0] iss0;
    m_id = 8'h00; m_ex = 8'h00; m_wb = 8'h00; m_issued = '0; m_bubble = '0;
    in_valid = 0; in_inst = 8'h00; issue_en = 0; flush = 0; rst = 1;

    // Reset state.
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("rst_inst_out", 32'(inst_out), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single ADD, then let it drain through the pipeline.
    step(1, 8'h46, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("single_issue", 32'(inst_out), 32'h46);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
    chk("single_idle_busy", 32'(busy), 32'h0);

    // Fill with issue held off; a ninth push is refused.
    for (int i = 0; i < 8; i++) step(1, 8'h41 + 8'(i), 0, 0, 0);
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'h0);
    step(1, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1, 0, 0);
      chk("drain_order", 32'(inst_out), 32'h41 + 32'(i));
    end
    step(0, 8'h00, 1, 0, 0);

    // Steady push-and-issue from a non-empty FIFO.
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h66, 0, 0, 0);
    iss0 = issued_cnt;
    for (int i = 0; i < 10; i++) step(1, 8'hC0 | 8'(i), 1, 0, 0);
    chk("stream_count", 32'(fifo_count), 32'd2);
    chk("stream_issued", 32'(issued_cnt - iss0), 32'd10);

    // Flush with one write in flight and a concurrent push.
    for (int i = 0; i < 5; i++) step(1, 8'h90 + 8'(i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hAA, 1, 1, 0);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_out", 32'(inst_out), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);

    // NOP entry: counted as issued but not tracked for writeback.
    step(1, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("nop_busy", 32'(busy), 32'h0);

    // Reset with entries queued and writes in flight.
    for (int i = 0; i < 5; i++) step(1, 8'h5A + 8'(i), (i >= 3), 0, 0);
    step(1, 8'h77, 0, 0, 1);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_issued", 32'(issued_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
